csr_regfile: RTL and testbench

//  Architectural CSR file for the LA32 pipeline; successor to the CSR opcode decode stage.

---
 rtl/csr_regfile_pkg.sv | 31 +++
 rtl/csr_regfile_timer.sv | 58 +++++
 rtl/csr_regfile.sv | 140 ++++++++++++++
 tb/tb_csr_regfile.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/csr_regfile_pkg.sv
// Shared CSR addresses, writable-bit masks and field positions for the LA32 CSR file.
package csr_regfile_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [31:0] WR_CRMD   = 32'h0000_01FF;
  localparam logic [31:0] WR_PRMD   = 32'h0000_0007;
  localparam logic [31:0] WR_ECFG   = 32'h0000_1BFF;
  localparam logic [31:0] WR_ESTAT  = 32'h0000_0003;
  localparam logic [31:0] WR_EENTRY = 32'hFFFF_FFC0;

  localparam int CRMD_IE       = 2;
  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;

  function automatic logic [31:0] csr_rmw(input logic [31:0] old_v, input logic [31:0] wval,
                                          input logic [31:0] m);
    return (old_v & ~m) | (wval & m);
  endfunction

endpackage

// File: rtl/csr_regfile_timer.sv
// Stable-counter timer: TCFG register, TVAL down-counter with reload, and the ESTAT.IS[11] flag.
module csr_regfile_timer
  import csr_regfile_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tcfg_we_i,
  input  logic [TIMER_W-1:0] tcfg_wvalue_i,
  input  logic [TIMER_W-1:0] tcfg_wmask_i,
  input  logic               ticlr_i,
  output logic [TIMER_W-1:0] tcfg_o,
  output logic [TIMER_W-1:0] tval_o,
  output logic               ti_o
);

  localparam logic [TIMER_W-1:0] TVAL_IDLE = '1;

  logic [TIMER_W-1:0] tcfg_q, tcfg_d, tval_q, tval_d;
  logic               ti_q, ti_d;

  always_comb begin
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    ti_d   = ti_q;
    if (tcfg_we_i) begin
      tcfg_d = (tcfg_q & ~tcfg_wmask_i) | (tcfg_wvalue_i & tcfg_wmask_i);
      // Enabling write restarts the count; disabling write leaves TVAL frozen.
      if (tcfg_d[TCFG_EN]) tval_d = {tcfg_d[TIMER_W-1:2], 2'b00};
    end else if (tcfg_q[TCFG_EN] && tval_q != TVAL_IDLE) begin
      if (tval_q == '0)
        tval_d = tcfg_q[TCFG_PERIODIC] ? {tcfg_q[TIMER_W-1:2], 2'b00} : TVAL_IDLE;
      else
        tval_d = tval_q - TIMER_W'(1);
    end
    if (ticlr_i) ti_d = 1'b0;
    // Set is applied after clear so a coincident expiry is never lost.
    if (tcfg_q[TCFG_EN] && tval_q == '0) ti_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg_q <= '0;
      tval_q <= TVAL_IDLE;
      ti_q   <= 1'b0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end

  assign tcfg_o = tcfg_q;
  assign tval_o = tval_q;
  assign ti_o   = ti_q;

endmodule

// File: rtl/csr_regfile.sv
// LA32 architectural CSR file: masked RMW writes, exception/ERTN updates, interrupt sampling, timer.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter int          SAVE_NUM = 4,
  parameter int          TIMER_W  = 32,
  parameter logic [31:0] TID_RST  = 32'h0,
  parameter int          HWI_NUM  = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [13:0]        csr_num,
  output logic [31:0]        csr_rvalue,
  input  logic               csr_we,
  input  logic [31:0]        csr_wmask,
  input  logic [31:0]        csr_wvalue,
  input  logic               wb_ex,
  input  logic [5:0]         wb_ecode,
  input  logic [8:0]         wb_esubcode,
  input  logic [31:0]        wb_pc,
  input  logic               ertn_flush,
  input  logic [HWI_NUM-1:0] hw_int_in,
  input  logic               ipi_int_in,
  output logic [31:0]        ex_entry,
  output logic [31:0]        ertn_entry,
  output logic               has_int
);

  logic [31:0]        crmd_q, crmd_d, prmd_q, prmd_d, era_q, era_d;
  logic [31:0]        ecfg_q, eentry_q, tid_q, estat_rd;
  logic [31:0]        save_q [SAVE_NUM];
  logic [1:0]         estat_sw_q;
  logic [5:0]         ecode_q;
  logic [8:0]         esub_q;
  logic [HWI_NUM-1:0] hwi_q;
  logic               ipi_q, ti;
  logic [TIMER_W-1:0] tcfg, tval;
  logic               ticlr;

  assign ticlr = csr_we && csr_num == CSR_TICLR && csr_wvalue[0] && csr_wmask[0];

  csr_regfile_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk           (clk),
    .resetn        (resetn),
    .tcfg_we_i     (csr_we && csr_num == CSR_TCFG),
    .tcfg_wvalue_i (csr_wvalue[TIMER_W-1:0]),
    .tcfg_wmask_i  (csr_wmask[TIMER_W-1:0]),
    .ticlr_i       (ticlr),
    .tcfg_o        (tcfg),
    .tval_o        (tval),
    .ti_o          (ti)
  );

  // Field priority wb_ex > ertn_flush > csr_we; CRMD bits outside PLV/IE still take the write.
  always_comb begin
    crmd_d = (csr_we && csr_num == CSR_CRMD) ? csr_rmw(crmd_q, csr_wvalue, csr_wmask & WR_CRMD)
                                             : crmd_q;
    prmd_d = (csr_we && csr_num == CSR_PRMD) ? csr_rmw(prmd_q, csr_wvalue, csr_wmask & WR_PRMD)
                                             : prmd_q;
    era_d  = (csr_we && csr_num == CSR_ERA) ? csr_rmw(era_q, csr_wvalue, csr_wmask) : era_q;
    if (wb_ex) begin
      crmd_d[2:0] = 3'b000;
      prmd_d[2:0] = crmd_q[2:0];
      era_d       = wb_pc;
    end else if (ertn_flush) begin
      crmd_d[2:0] = prmd_q[2:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_q     <= 32'h8;
      prmd_q     <= '0;
      era_q      <= '0;
      ecfg_q     <= '0;
      eentry_q   <= '0;
      tid_q      <= TID_RST;
      estat_sw_q <= '0;
      ecode_q    <= '0;
      esub_q     <= '0;
      hwi_q      <= '0;
      ipi_q      <= 1'b0;
      for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
    end else begin
      crmd_q <= crmd_d;
      prmd_q <= prmd_d;
      era_q  <= era_d;
      hwi_q  <= hw_int_in;
      ipi_q  <= ipi_int_in;
      if (csr_we && csr_num == CSR_ECFG)
        ecfg_q <= csr_rmw(ecfg_q, csr_wvalue, csr_wmask & WR_ECFG);
      if (csr_we && csr_num == CSR_EENTRY)
        eentry_q <= csr_rmw(eentry_q, csr_wvalue, csr_wmask & WR_EENTRY);
      if (csr_we && csr_num == CSR_TID)
        tid_q <= csr_rmw(tid_q, csr_wvalue, csr_wmask);
      if (csr_we && csr_num == CSR_ESTAT)
        estat_sw_q <= (estat_sw_q & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
      if (wb_ex) begin
        ecode_q <= wb_ecode;
        esub_q  <= wb_esubcode;
      end
      for (int i = 0; i < SAVE_NUM; i++)
        if (csr_we && csr_num == CSR_SAVE0 + 14'(i))
          save_q[i] <= csr_rmw(save_q[i], csr_wvalue, csr_wmask);
    end
  end

  always_comb begin
    estat_rd              = '0;
    estat_rd[1:0]         = estat_sw_q;
    estat_rd[2+:HWI_NUM]  = hwi_q;
    estat_rd[11]          = ti;
    estat_rd[12]          = ipi_q;
    estat_rd[21:16]       = ecode_q;
    estat_rd[30:22]       = esub_q;
  end

  always_comb begin
    csr_rvalue = '0;
    for (int i = 0; i < SAVE_NUM; i++)
      if (csr_num == CSR_SAVE0 + 14'(i)) csr_rvalue = save_q[i];
    case (csr_num)
      CSR_CRMD:   csr_rvalue = crmd_q;
      CSR_PRMD:   csr_rvalue = prmd_q;
      CSR_ECFG:   csr_rvalue = ecfg_q;
      CSR_ESTAT:  csr_rvalue = estat_rd;
      CSR_ERA:    csr_rvalue = era_q;
      CSR_EENTRY: csr_rvalue = eentry_q;
      CSR_TID:    csr_rvalue = tid_q;
      CSR_TCFG:   csr_rvalue = 32'(tcfg);
      CSR_TVAL:   csr_rvalue = 32'(tval);
      default:    ;
    endcase
  end

  assign ex_entry   = eentry_q;
  assign ertn_entry = era_q;
  assign has_int    = crmd_q[CRMD_IE] & |(estat_rd[12:0] & ecfg_q[12:0]);

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: reset, masked writes, exception/ERTN, timer modes, priorities.
module tb_csr_regfile;
  import csr_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry, ertn_entry;
  logic        has_int;

  int tests = 0;
  int failed = 0;

  csr_regfile dut (
    .clk(clk), .resetn(resetn), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_csr(input string tag, input logic [13:0] n, input logic [31:0] m,
                         input logic [31:0] exp);
    csr_num = n;
    #1;
    chk(tag, csr_rvalue & m, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] v, input logic [31:0] m);
    csr_num = n; csr_wvalue = v; csr_wmask = m; csr_we = 1'b1;
    step();
    csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; ertn_flush = 1'b0;
    hw_int_in = '0; ipi_int_in = 1'b0;
    step(); step();
    resetn = 1'b1;
    step();

    chk_csr("rst_crmd", CSR_CRMD, 32'hFFFF_FFFF, 32'h8);
    chk_csr("rst_tval", CSR_TVAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_csr("rst_tid", CSR_TID, 32'hFFFF_FFFF, 32'h0);
    chk("rst_has_int", 32'(has_int), 32'h0);
    chk("rst_ex_entry", ex_entry, 32'h0);
    chk("rst_ertn_entry", ertn_entry, 32'h0);

    // Masked write: bit10 of ECFG is not writable
    wr(CSR_ECFG, 32'h0000_FFFF, 32'h0000_0FF0);
    chk_csr("ecfg_masked", CSR_ECFG, 32'hFFFF_FFFF, 32'h0000_0BF0);
    wr(CSR_ECFG, 32'h0, 32'hFFFF_FFFF);
    wr(CSR_EENTRY, 32'h1C00_8FFF, 32'hFFFF_FFFF);
    chk_csr("eentry_low_ro", CSR_EENTRY, 32'hFFFF_FFFF, 32'h1C00_8FC0);
    chk("ex_entry", ex_entry, 32'h1C00_8FC0);

    // Exception then ERTN
    wr(CSR_CRMD, 32'h7, 32'hFFFF_FFFF);
    chk_csr("crmd_wr", CSR_CRMD, 32'hFFFF_FFFF, 32'h7);
    wb_ex = 1'b1; wb_pc = 32'h1C00_0100; wb_ecode = 6'hB; wb_esubcode = 9'h0;
    step();
    wb_ex = 1'b0;
    chk_csr("ex_crmd", CSR_CRMD, 32'h7, 32'h0);
    chk_csr("ex_prmd", CSR_PRMD, 32'h7, 32'h7);
    chk_csr("ex_era", CSR_ERA, 32'hFFFF_FFFF, 32'h1C00_0100);
    chk_csr("ex_estat", CSR_ESTAT, 32'hFFFF_FFFF, 32'h000B_0000);
    ertn_flush = 1'b1;
    step();
    ertn_flush = 1'b0;
    chk_csr("ertn_crmd", CSR_CRMD, 32'h7, 32'h7);
    chk("ertn_entry", ertn_entry, 32'h1C00_0100);

    // Hardware interrupt lines sampled, but not enabled in LIE
    hw_int_in = 8'h05;
    step();
    chk_csr("estat_hwi", CSR_ESTAT, 32'h0000_1FFC, 32'h0000_0014);
    chk("hwi_masked_no_int", 32'(has_int), 32'h0);
    hw_int_in = 8'h00;

    // Timer one-shot
    wr(CSR_TCFG, 32'h9, 32'hFFFF_FFFF);
    chk_csr("os_tval_load", CSR_TVAL, 32'hFFFF_FFFF, 32'h8);
    for (int k = 7; k >= 0; k--) begin
      step();
      chk_csr("os_tval_dec", CSR_TVAL, 32'hFFFF_FFFF, 32'(k));
    end
    chk_csr("os_ti_before", CSR_ESTAT, 32'h800, 32'h0);
    step();
    chk_csr("os_tval_wrap", CSR_TVAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_csr("os_ti_set", CSR_ESTAT, 32'h800, 32'h800);
    chk("os_no_lie", 32'(has_int), 32'h0);
    step();
    chk_csr("os_tval_hold", CSR_TVAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(CSR_ECFG, 32'h800, 32'hFFFF_FFFF);
    chk("os_has_int", 32'(has_int), 32'h1);
    wr(CSR_TICLR, 32'h1, 32'h1);
    chk_csr("os_ticlr", CSR_ESTAT, 32'h800, 32'h0);
    chk("os_int_cleared", 32'(has_int), 32'h0);

    // Timer periodic
    wr(CSR_TCFG, 32'hB, 32'hFFFF_FFFF);
    for (int k = 0; k < 8; k++) step();
    chk_csr("per_tval_zero", CSR_TVAL, 32'hFFFF_FFFF, 32'h0);
    wr(CSR_TICLR, 32'h1, 32'hFFFF_FFFF);
    chk_csr("per_set_beats_clr", CSR_ESTAT, 32'h800, 32'h800);
    chk_csr("per_reload", CSR_TVAL, 32'hFFFF_FFFF, 32'h8);
    wr(CSR_TICLR, 32'h1, 32'hFFFF_FFFF);
    chk_csr("per_ticlr", CSR_ESTAT, 32'h800, 32'h0);
    chk_csr("per_tval7", CSR_TVAL, 32'hFFFF_FFFF, 32'h7);
    for (int k = 0; k < 8; k++) step();
    chk_csr("per_reload2", CSR_TVAL, 32'hFFFF_FFFF, 32'h8);
    chk_csr("per_ti_again", CSR_ESTAT, 32'h800, 32'h800);
    wr(CSR_TCFG, 32'h0, 32'hFFFF_FFFF);
    step();
    chk_csr("tcfg_freeze", CSR_TVAL, 32'hFFFF_FFFF, 32'h8);

    // Simultaneous csr_we and wb_ex on CRMD
    csr_num = CSR_CRMD; csr_wvalue = 32'h13; csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
    wb_ex = 1'b1; wb_pc = 32'h0000_0200;
    step();
    csr_we = 1'b0; wb_ex = 1'b0; csr_wmask = '0;
    chk_csr("sim_crmd", CSR_CRMD, 32'hFFFF_FFFF, 32'h10);
    chk_csr("sim_prmd", CSR_PRMD, 32'h7, 32'h7);

    // Scratch, TID, unmapped and read-only addresses
    wr(CSR_SAVE0, 32'h1234_5678, 32'hFFFF_FFFF);
    wr(CSR_SAVE0 + 14'd3, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    wr(CSR_TID, 32'h0000_00A5, 32'hFFFF_FFFF);
    wr(14'h07F, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(CSR_TVAL, 32'h0, 32'hFFFF_FFFF);
    chk_csr("unmapped_rd", 14'h07F, 32'hFFFF_FFFF, 32'h0);
    chk_csr("save0", CSR_SAVE0, 32'hFFFF_FFFF, 32'h1234_5678);
    chk_csr("save3", CSR_SAVE0 + 14'd3, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    chk_csr("save_oob", CSR_SAVE0 + 14'd4, 32'hFFFF_FFFF, 32'h0);
    chk_csr("tid", CSR_TID, 32'hFFFF_FFFF, 32'hA5);
    chk_csr("ecfg_kept", CSR_ECFG, 32'hFFFF_FFFF, 32'h800);
    chk_csr("tval_ro", CSR_TVAL, 32'hFFFF_FFFF, 32'h8);
    chk_csr("ticlr_rd0", CSR_TICLR, 32'hFFFF_FFFF, 32'h0);

    // Reset mid-run, asserted between clock edges
    wr(CSR_CRMD, 32'h4, 32'hFFFF_FFFF);
    wr(CSR_ECFG, 32'h4, 32'hFFFF_FFFF);
    hw_int_in = 8'h01;
    wr(CSR_TCFG, 32'h9, 32'hFFFF_FFFF);
    chk("pre_rst_has_int", 32'(has_int), 32'h1);
    #1;
    resetn = 1'b0;
    chk_csr("arst_crmd", CSR_CRMD, 32'hFFFF_FFFF, 32'h8);
    chk_csr("arst_tval", CSR_TVAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("arst_has_int", 32'(has_int), 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
